// File: rtl/spi_frame_if.sv
// SPI frame controller bus: conditioned SPI inputs, shift-register hooks and memory strobes.
// Optional burst address increment (addr_inc) exists only when SPI_AUTOINC_EN is defined.
interface spi_frame_if #(
  parameter int DATA_W = 8
);
  logic              cs_n;
  logic              sclk_rise;
  logic              sclk_fall;
  logic              mosi;
  logic [DATA_W-1:0] sr_q;
  logic [1:0]        sr_mode;
  logic              sr_serial_in;
  logic              addr_we;
  logic              dm_we;
  logic              miso;
  logic              miso_bufe;
`ifdef SPI_AUTOINC_EN
  logic              addr_inc;
`endif

  modport slave (
    input  cs_n, sclk_rise, sclk_fall, mosi, sr_q,
`ifdef SPI_AUTOINC_EN
    output addr_inc,
`endif
    output sr_mode, sr_serial_in, addr_we, dm_we, miso, miso_bufe
  );

  modport master (
    output cs_n, sclk_rise, sclk_fall, mosi, sr_q,
`ifdef SPI_AUTOINC_EN
    input  addr_inc,
`endif
    input  sr_mode, sr_serial_in, addr_we, dm_we, miso, miso_bufe
  );
endinterface

// File: rtl/spi_frame_ctrl.sv
// SPI slave frame controller: sequences header/data shifting, address latch, memory write and MISO enable.
// Define SPI_AUTOINC_EN for burst mode (auto address increment while cs_n stays low).
module spi_frame_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7
) (
  input  logic       clk,
  input  logic       reset,
  spi_frame_if.slave ifc
);
  localparam int              CNT_W  = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE_S       = 3'd0,
    GET_ADDR_S   = 3'd1,
    ADDR_LATCH_S = 3'd2,
    RD_LOAD_S    = 3'd3,
    RD_SHIFT_S   = 3'd4,
    WR_DATA_S    = 3'd5,
    WR_COMMIT_S  = 3'd6,
    DONE_S       = 3'd7
  } state_t;

  localparam logic [1:0] HOLD_C  = 2'b00;
  localparam logic [1:0] LEFT_C  = 2'b10;
  localparam logic [1:0] PLOAD_C = 2'b11;

  state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0] bit_cnt_r, bit_cnt_nxt_s;
  logic             rw_r, rw_nxt_s;
  logic             abort_s;
  logic [1:0]       sr_mode_s;
  logic             addr_we_s, dm_we_s, miso_bufe_s;
`ifdef SPI_AUTOINC_EN
  logic             addr_inc_s;
`endif
  // Middle header bits go straight to the external address latch, not used here.
  logic             unused_s;

  // Chip select dropping mid-frame overrides everything except reset.
  assign abort_s  = ifc.cs_n && (state_r != IDLE_S);
  assign unused_s = ^ifc.sr_q[ADDR_W-1:1];

  // State, bit counter and rw flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE_S;
      bit_cnt_r <= '0;
      rw_r      <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      bit_cnt_r <= bit_cnt_nxt_s;
      rw_r      <= rw_nxt_s;
    end
  end

  // Next-state logic; each shifting state consumes only its own SCLK edge.
  always_comb begin
    state_nxt_s   = state_r;
    bit_cnt_nxt_s = bit_cnt_r;
    rw_nxt_s      = rw_r;
    if (abort_s) begin
      state_nxt_s   = IDLE_S;
      bit_cnt_nxt_s = '0;
    end else begin
      case (state_r)
        IDLE_S: begin
          if (!ifc.cs_n) begin
            state_nxt_s   = GET_ADDR_S;
            bit_cnt_nxt_s = '0;
          end else begin
            state_nxt_s = IDLE_S;
          end
        end
        GET_ADDR_S, WR_DATA_S: begin
          if (ifc.sclk_rise) begin
            bit_cnt_nxt_s = bit_cnt_r + CNT_W'(1);
            if (bit_cnt_r == LAST_C) begin
              state_nxt_s = (state_r == GET_ADDR_S) ? ADDR_LATCH_S : WR_COMMIT_S;
            end else begin
              state_nxt_s = state_r;
            end
          end else begin
            state_nxt_s = state_r;
          end
        end
        ADDR_LATCH_S: begin
          rw_nxt_s      = ifc.sr_q[0];
          bit_cnt_nxt_s = '0;
          state_nxt_s   = ifc.sr_q[0] ? RD_LOAD_S : WR_DATA_S;
        end
        RD_LOAD_S: begin
          state_nxt_s = RD_SHIFT_S;
        end
        RD_SHIFT_S: begin
          if (ifc.sclk_fall) begin
            bit_cnt_nxt_s = bit_cnt_r + CNT_W'(1);
            state_nxt_s   = (bit_cnt_r == LAST_C) ? DONE_S : RD_SHIFT_S;
          end else begin
            state_nxt_s = RD_SHIFT_S;
          end
        end
        WR_COMMIT_S: begin
          state_nxt_s = DONE_S;
        end
        DONE_S: begin
`ifdef SPI_AUTOINC_EN
          if (rw_r) begin
            state_nxt_s   = RD_LOAD_S;
            bit_cnt_nxt_s = '0;
          end else if (ifc.sclk_rise) begin
            // The burst rise already carries the first data bit.
            state_nxt_s   = WR_DATA_S;
            bit_cnt_nxt_s = CNT_W'(1);
          end else begin
            state_nxt_s = DONE_S;
          end
`else
          state_nxt_s = DONE_S;
`endif
        end
        default: begin
          state_nxt_s   = IDLE_S;
          bit_cnt_nxt_s = '0;
        end
      endcase
    end
  end

  // Output decode from registered state and this cycle's edge pulses.
  always_comb begin
    sr_mode_s   = HOLD_C;
    addr_we_s   = 1'b0;
    dm_we_s     = 1'b0;
    miso_bufe_s = 1'b0;
`ifdef SPI_AUTOINC_EN
    addr_inc_s  = 1'b0;
`endif
    if (abort_s) begin
      sr_mode_s = HOLD_C;
    end else begin
      case (state_r)
        GET_ADDR_S, WR_DATA_S: sr_mode_s = ifc.sclk_rise ? LEFT_C : HOLD_C;
        ADDR_LATCH_S:          addr_we_s = 1'b1;
        RD_LOAD_S: begin
          sr_mode_s   = PLOAD_C;
          miso_bufe_s = 1'b1;
        end
        RD_SHIFT_S: begin
          sr_mode_s   = ifc.sclk_fall ? LEFT_C : HOLD_C;
          miso_bufe_s = 1'b1;
        end
        WR_COMMIT_S:           dm_we_s = 1'b1;
        DONE_S: begin
          miso_bufe_s = rw_r;
`ifdef SPI_AUTOINC_EN
          if (rw_r) begin
            addr_inc_s = 1'b1;
          end else if (ifc.sclk_rise) begin
            sr_mode_s  = LEFT_C;
            addr_inc_s = 1'b1;
          end else begin
            sr_mode_s = HOLD_C;
          end
`endif
        end
        default:               sr_mode_s = HOLD_C;
      endcase
    end
  end

  assign ifc.sr_mode      = sr_mode_s;
  assign ifc.addr_we      = addr_we_s;
  assign ifc.dm_we        = dm_we_s;
  assign ifc.miso_bufe    = miso_bufe_s;
  assign ifc.sr_serial_in = ifc.mosi;
  assign ifc.miso         = ifc.sr_q[DATA_W-1];
`ifdef SPI_AUTOINC_EN
  assign ifc.addr_inc     = addr_inc_s;
`endif
endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Bench for spi_frame_ctrl: models the shift register, address latch and data memory around the DUT,
// runs directed and random frames and checks against a transaction-level golden memory.
module tb_spi_frame_ctrl;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 7;
`ifdef SPI_AUTOINC_EN
  localparam logic DONE_EDGE = 1'b0;
`else
  localparam logic DONE_EDGE = 1'b1;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spi_frame_if #(.DATA_W(DATA_W)) bus ();

  spi_frame_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .ifc   (bus.slave)
  );

  // Surrounding hardware: shift register, address latch and data memory.
  logic [7:0] env_sr;
  logic [6:0] lat_addr;
  logic [7:0] mem  [0:127];
  logic [7:0] gold [0:127];

  function automatic logic [7:0] init_byte(input int i);
    return 8'(i * 37 + 11);
  endfunction

  assign bus.sr_q = env_sr;

  always_ff @(posedge clk) begin
    if (reset) begin
      env_sr   <= 8'h00;
      lat_addr <= 7'h00;
      for (int i = 0; i < 128; i++) mem[i] <= init_byte(i);
    end else begin
      case (bus.sr_mode)
        2'b01:   env_sr <= {bus.sr_serial_in, env_sr[7:1]};
        2'b10:   env_sr <= {env_sr[6:0], bus.sr_serial_in};
        2'b11:   env_sr <= mem[lat_addr];
        default: env_sr <= env_sr;
      endcase
      if (bus.addr_we) lat_addr <= env_sr[7:1];
`ifdef SPI_AUTOINC_EN
      else if (bus.addr_inc) lat_addr <= lat_addr + 7'd1;
`endif
      if (bus.dm_we) mem[lat_addr] <= env_sr;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int n_aw, n_dm, n_pl, n_inc;
  logic [7:0] aw_q, dm_q;
  logic [1:0] s_mode;
  logic       s_bufe, s_miso;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs after posedge, sample at negedge, return after next posedge.
  task automatic cyc(input logic cs, input logic r, input logic f, input logic m);
    bus.cs_n = cs; bus.sclk_rise = r; bus.sclk_fall = f; bus.mosi = m;
    @(negedge clk);
    s_mode = bus.sr_mode; s_bufe = bus.miso_bufe; s_miso = bus.miso;
    if (bus.addr_we) begin n_aw++; aw_q = bus.sr_q; end
    if (bus.dm_we)   begin n_dm++; dm_q = bus.sr_q; end
    if (bus.sr_mode == 2'b11) n_pl++;
`ifdef SPI_AUTOINC_EN
    if (bus.addr_inc) n_inc++;
`endif
    check_eq("serial_in", 32'(bus.sr_serial_in), 32'(m));
    @(posedge clk); #1;
  endtask

  task automatic send_hdr(input logic [7:0] hdr);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, 1'($urandom), hdr[7-i]);
      check_eq("hdr_left", 32'(s_mode), 32'(2'b10));
      if (i < 7 && $urandom_range(0, 1) == 1) cyc(1'b0, 1'b0, 1'b1, 1'($urandom));
    end
  endtask

  task automatic wr_data(input logic [7:0] d, input int stop_at);
    for (int i = 0; i < 8; i++) begin
      if (i == stop_at) break;
      cyc(1'b0, 1'b1, 1'($urandom), d[7-i]);
      check_eq("wr_left", 32'(s_mode), 32'(2'b10));
      if (i < 7 && $urandom_range(0, 1) == 1) cyc(1'b0, 1'b0, 1'b1, 1'($urandom));
    end
  endtask

  // One frame; abort_at = number of data rises before cs_n goes high (0 = complete frame).
  task automatic frame(input logic [6:0] a, input logic rw, input logic [7:0] d,
                       input int abort_at, input logic junk);
    logic [7:0] exp_rd;
    n_aw = 0; n_dm = 0; n_pl = 0;
    exp_rd = gold[a];
    send_hdr({a, rw});
    cyc(1'b0, junk, 1'b0, 1'($urandom));
    check_eq("latch_hold", 32'(s_mode), 32'(2'b00));
    check_eq("aw_count", n_aw, 1);
    check_eq("aw_q", 32'(aw_q), 32'({a, rw}));
    if (rw) begin
      cyc(1'b0, junk, junk, 1'($urandom));
      check_eq("rd_pload", 32'(s_mode), 32'(2'b11));
      check_eq("rd_bufe", 32'(s_bufe), 32'd1);
      for (int i = 0; i < 8; i++) begin
        cyc(1'b0, 1'b1, 1'b0, 1'($urandom));
        check_eq("rd_rise_hold", 32'(s_mode), 32'(2'b00));
        cyc(1'b0, 1'($urandom), 1'b1, 1'($urandom));
        check_eq("miso", 32'(s_miso), 32'(exp_rd[7-i]));
        check_eq("rd_shift_bufe", 32'(s_bufe), 32'd1);
        check_eq("rd_left", 32'(s_mode), 32'(2'b10));
      end
`ifndef SPI_AUTOINC_EN
      cyc(1'b0, 1'b1, 1'b1, 1'b1);
      check_eq("rd_done_hold", 32'(s_mode), 32'(2'b00));
      check_eq("rd_done_bufe", 32'(s_bufe), 32'd1);
`endif
      check_eq("pload_count", n_pl, 1);
      check_eq("rd_no_dm", n_dm, 0);
    end else begin
      wr_data(d, (abort_at == 0) ? 8 : abort_at);
      if (abort_at == 0) begin
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("dm_count", n_dm, 1);
        check_eq("dm_q", 32'(dm_q), 32'(d));
        gold[a] = d;
        cyc(1'b0, DONE_EDGE, DONE_EDGE, 1'b1);
        check_eq("wr_done_hold", 32'(s_mode), 32'(2'b00));
        check_eq("wr_done_bufe", 32'(s_bufe), 32'd0);
        check_eq("dm_once", n_dm, 1);
      end else begin
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        check_eq("abort_hold", 32'(s_mode), 32'(2'b00));
        check_eq("abort_bufe", 32'(s_bufe), 32'd0);
        check_eq("abort_no_dm", n_dm, 0);
      end
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [6:0] a;
    int ab;
    for (int i = 0; i < 128; i++) gold[i] = init_byte(i);
    reset = 1'b1;
    bus.cs_n = 1'b1; bus.sclk_rise = 1'b0; bus.sclk_fall = 1'b0; bus.mosi = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_aw = 0; n_dm = 0; n_inc = 0;
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    check_eq("rst_mode", 32'(s_mode), 32'(2'b00));
    check_eq("rst_bufe", 32'(s_bufe), 32'd0);
    check_eq("rst_pulses", n_aw + n_dm, 0);
    reset = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);

    // Reset after three header rises.
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b1);
    reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    n_aw = 0; n_dm = 0;
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    check_eq("midrst_mode", 32'(s_mode), 32'(2'b00));
    check_eq("midrst_bufe", 32'(s_bufe), 32'd0);
    check_eq("midrst_pulses", n_aw + n_dm, 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);

    frame(7'h2A, 1'b0, 8'hC3, 0, 1'b0);
    frame(7'h2A, 1'b0, 8'hA5, 0, 1'b1);
    frame(7'h2A, 1'b1, 8'h00, 0, 1'b0);
    frame(7'h2A, 1'b0, 8'hFF, 4, 1'b0);
    frame(7'h2A, 1'b0, 8'h3C, 8, 1'b0);
    frame(7'h2A, 1'b1, 8'h00, 0, 1'b1);

`ifdef SPI_AUTOINC_EN
    n_aw = 0; n_dm = 0; n_inc = 0;
    send_hdr({7'h05, 1'b0});
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    wr_data(8'h10, 8);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("burst_dm1", 32'(dm_q), 32'h10);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("burst_inc0", n_inc, 0);
    wr_data(8'h20, 8);
    check_eq("burst_inc1", n_inc, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("burst_dm_count", n_dm, 2);
    check_eq("burst_dm2", 32'(dm_q), 32'h20);
    gold[5] = 8'h10;
    gold[6] = 8'h20;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
`endif

    for (int k = 0; k < 60; k++) begin
      a  = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'($urandom_range(40, 45));
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 8)) : 0;
      frame(a, 1'($urandom), 8'($urandom), ab, 1'($urandom));
    end

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 128; i++) check_eq("mem_final", 32'(mem[i]), 32'(gold[i]));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
